// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Port 0 is instruction fetch and port 1 is load/store.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam int unsigned PORT_IF = 0;
    localparam int unsigned PORT_LS = 1;

    function automatic logic [1:0] port_onehot(input logic port);
        return port ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side signals of mem_arbiter.
// The slave modport is the arbiter's view; the master modport is the view of the requesters and the memory.
interface mem_arbiter_if #(
    parameter int unsigned ADDR_W = 3,
    parameter int unsigned DATA_W = 32
);
    logic [1:0]        req;
    logic [1:0]        we;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic [1:0]        gnt;
    logic [1:0]        rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              mem_dmem;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data_w;
    logic [DATA_W-1:0] mem_data_r;

    modport slave (
        input  req, we, addr0, addr1, wdata0, wdata1, mem_data_r,
        output gnt, rsp_valid, rsp_data, mem_dmem, mem_addr, mem_data_w
    );

    modport master (
        output req, we, addr0, addr1, wdata0, wdata1, mem_data_r,
        input  gnt, rsp_valid, rsp_data, mem_dmem, mem_addr, mem_data_w
    );
endinterface

// File: rtl/mem_arbiter_rr.sv
// Two-input round-robin pick with a last-grant register.
// On contention, the port that was not granted most recently wins.
module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] gnt
);
    // Index of the most recently granted port; resetting to 1 lets port 0 win first.
    logic r_last;

    always_comb begin
        gnt = '0;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = r_last ? 2'b01 : 2'b10;
            default: gnt = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last <= 1'b1;
        end else if (update && (|gnt)) begin
            r_last <= gnt[PORT_LS];
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares a single-port synchronous-read memory between two requesters.
// Each access takes three cycles: grant (IDLE), ACCESS, then RESP.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = 3,
    parameter int unsigned DATA_W = 32
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);
    state_t            r_state;
    state_t            w_next;
    logic [1:0]        w_arb_gnt;
    logic              w_idle;
    logic              w_take;
    logic              r_port;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;

    assign w_idle = (r_state == IDLE);
    assign w_take = w_idle && (|bus.req);

    rr_arbiter2 u_rr (
        .clk    (clk),
        .rst    (rst),
        .req    (bus.req),
        .update (w_idle),
        .gnt    (w_arb_gnt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Write enable is derived from the state register, so it drops as soon as reset is asserted.
    always_comb begin
        w_next        = r_state;
        bus.gnt       = '0;
        bus.rsp_valid = '0;
        bus.rsp_data  = '0;
        bus.mem_dmem  = 1'b0;
        case (r_state)
            IDLE: begin
                bus.gnt = w_arb_gnt;
                if (|bus.req) begin
                    w_next = ACCESS;
                end
            end
            ACCESS: begin
                bus.mem_dmem = r_we;
                w_next       = RESP;
            end
            RESP: begin
                bus.rsp_valid = port_onehot(r_port);
                bus.rsp_data  = r_we ? '0 : bus.mem_data_r;
                w_next        = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_port  <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_take) begin
            r_port  <= w_arb_gnt[PORT_LS];
            r_we    <= w_arb_gnt[PORT_LS] ? bus.we[PORT_LS] : bus.we[PORT_IF];
            r_addr  <= w_arb_gnt[PORT_LS] ? bus.addr1 : bus.addr0;
            r_wdata <= w_arb_gnt[PORT_LS] ? bus.wdata1 : bus.wdata0;
        end
    end

    assign bus.mem_addr   = r_addr;
    assign bus.mem_data_w = r_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random traffic,
// checked against a transaction-level model of the arbiter and memory.
module tb_mem_arbiter;
    localparam int unsigned AW = 3;
    localparam int unsigned DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Behavioural memory: synchronous read, one-cycle latency.
    logic [DW-1:0] ram [0:7] = '{default: '0};
    always @(posedge clk) begin
        if (bus.mem_dmem) ram[bus.mem_addr] <= bus.mem_data_w;
        bus.mem_data_r <= ram[bus.mem_addr];
    end

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model: m_busy counts cycles left before the arbiter can grant again.
    int            m_busy;
    logic          m_last;
    logic          m_port;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wd;
    logic [DW-1:0] m_mem [0:7] = '{default: '0};

    logic [1:0]    exp_gnt;
    logic [1:0]    exp_rsp;
    logic [DW-1:0] exp_rdata;
    logic          exp_dmem;
    logic [71:0]   exp_vec;

    function automatic logic [1:0] pick(input logic [1:0] rq);
        if (rq == 2'b11) return m_last ? 2'b01 : 2'b10;
        return rq;
    endfunction

    function automatic logic [71:0] obs_vec();
        return {bus.gnt, bus.rsp_valid, bus.rsp_data, bus.mem_dmem, bus.mem_addr, bus.mem_data_w};
    endfunction

    task automatic model_reset();
        m_busy = 0;
        m_last = 1'b1;
        m_port = 1'b0;
        m_we   = 1'b0;
        m_addr = '0;
        m_wd   = '0;
    endtask

    // Drive inputs just after a rising edge, let them settle, and form the expected outputs.
    task automatic apply(input logic [1:0] rq, input logic [1:0] wv,
                         input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                         input logic [DW-1:0] d0, input logic [DW-1:0] d1);
        bus.req = rq; bus.we = wv;
        bus.addr0 = a0; bus.addr1 = a1;
        bus.wdata0 = d0; bus.wdata1 = d1;
        #1;
        exp_gnt = '0; exp_rsp = '0; exp_rdata = '0; exp_dmem = 1'b0;
        if (m_busy == 0) begin
            exp_gnt = pick(rq);
        end else if (m_busy == 2) begin
            exp_dmem = m_we;
        end else begin
            exp_rsp   = m_port ? 2'b10 : 2'b01;
            exp_rdata = m_we ? '0 : m_mem[m_addr];
        end
        exp_vec = {exp_gnt, exp_rsp, exp_rdata, exp_dmem, m_addr, m_wd};
    endtask

    task automatic advance();
        logic [1:0] w;
        @(posedge clk);
        if (m_busy == 0) begin
            w = pick(bus.req);
            if (w != 2'b00) begin
                m_last = w[1];
                m_port = w[1];
                m_we   = bus.we[w[1]];
                m_addr = w[1] ? bus.addr1 : bus.addr0;
                m_wd   = w[1] ? bus.wdata1 : bus.wdata0;
                m_busy = 2;
            end
        end else begin
            if (m_busy == 2 && m_we) m_mem[m_addr] = m_wd;
            m_busy = m_busy - 1;
        end
        #1;
    endtask

    task automatic test_reset();
        apply(2'b00, 2'b00, 0, 0, 0, 0);
        n_cmp++;
        if ({bus.gnt, bus.rsp_valid, bus.rsp_data, bus.mem_dmem, bus.mem_addr, bus.mem_data_w} !== 70'd0) begin
            n_fail++; $display("FAIL reset_values: got %h want 0", obs_vec());
        end
        advance();
        // Write of an already-zero word aborted in ACCESS: either outcome leaves memory consistent.
        apply(2'b01, 2'b01, 5, 0, 0, 0);
        n_cmp++; if (obs_vec() !== exp_vec) begin n_fail++; $display("FAIL reset_wr_grant: got %h want %h", obs_vec(), exp_vec); end
        advance();
        apply(2'b00, 2'b00, 0, 0, 0, 0);
        n_cmp++; if (obs_vec() !== exp_vec) begin n_fail++; $display("FAIL reset_wr_access: got %h want %h", obs_vec(), exp_vec); end
        rst = 1'b0; #1;
        n_cmp++; if (bus.mem_dmem !== 1'b0) begin n_fail++; $display("FAIL reset_dmem_drop: got %b want 0", bus.mem_dmem); end
        model_reset(); #1; rst = 1'b1;
        advance();
        // Read aborted mid-RESP.
        apply(2'b01, 2'b00, 5, 0, 0, 0);
        n_cmp++; if (obs_vec() !== exp_vec) begin n_fail++; $display("FAIL reset_rd_grant: got %h want %h", obs_vec(), exp_vec); end
        advance();
        for (int i = 0; i < 2; i++) begin
            apply(2'b00, 2'b00, 0, 0, 0, 0);
            n_cmp++; if (obs_vec() !== exp_vec) begin n_fail++; $display("FAIL reset_rd_seq%0d: got %h want %h", i, obs_vec(), exp_vec); end
            if (i == 0) advance();
        end
        rst = 1'b0; #1;
        n_cmp++;
        if (bus.rsp_valid !== 2'b00 || bus.mem_dmem !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid_resp: got rsp_valid=%b dmem=%b want 00/0", bus.rsp_valid, bus.mem_dmem);
        end
        model_reset(); #1; rst = 1'b1;
        advance();
        apply(2'b11, 2'b00, 1, 6, 0, 0);
        n_cmp++; if (bus.gnt !== 2'b01) begin n_fail++; $display("FAIL reset_first_contention: got %b want 01", bus.gnt); end
        n_cmp++; if (obs_vec() !== exp_vec) begin n_fail++; $display("FAIL reset_contention_vec: got %h want %h", obs_vec(), exp_vec); end
        advance();
        for (int i = 0; i < 2; i++) begin
            apply(2'b10, 2'b00, 1, 6, 0, 0);
            n_cmp++; if (obs_vec() !== exp_vec) begin n_fail++; $display("FAIL reset_drain%0d: got %h want %h", i, obs_vec(), exp_vec); end
            advance();
        end
        // Port 1 still requesting: it takes the next slot.
        apply(2'b10, 2'b00, 1, 6, 0, 0);
        n_cmp++; if (bus.gnt !== 2'b10) begin n_fail++; $display("FAIL reset_second_grant: got %b want 10", bus.gnt); end
        advance();
        for (int i = 0; i < 2; i++) begin
            apply(2'b00, 2'b00, 0, 0, 0, 0);
            n_cmp++; if (obs_vec() !== exp_vec) begin n_fail++; $display("FAIL reset_tail%0d: got %h want %h", i, obs_vec(), exp_vec); end
            advance();
        end
    endtask

    task automatic test_write_read();
        apply(2'b10, 2'b10, 0, 2, 0, 32'hAAAAAAAA);
        n_cmp++; if (bus.gnt !== 2'b10 || bus.mem_dmem !== 1'b0) begin n_fail++; $display("FAIL wr_grant: got gnt=%b dmem=%b want 10/0", bus.gnt, bus.mem_dmem); end
        advance();
        apply(2'b00, 2'b00, 0, 0, 0, 0);
        n_cmp++; if (bus.mem_dmem !== 1'b1 || bus.mem_addr !== 3'd2) begin n_fail++; $display("FAIL wr_access: got dmem=%b addr=%0d want 1/2", bus.mem_dmem, bus.mem_addr); end
        advance();
        apply(2'b00, 2'b00, 0, 0, 0, 0);
        n_cmp++;
        if (bus.rsp_valid !== 2'b10 || bus.mem_dmem !== 1'b0 || bus.rsp_data !== 32'h0) begin
            n_fail++; $display("FAIL wr_resp: got rsp_valid=%b dmem=%b data=%h want 10/0/0", bus.rsp_valid, bus.mem_dmem, bus.rsp_data);
        end
        advance();
        apply(2'b10, 2'b00, 0, 2, 0, 0);
        n_cmp++; if (obs_vec() !== exp_vec) begin n_fail++; $display("FAIL rd_grant: got %h want %h", obs_vec(), exp_vec); end
        advance();
        apply(2'b00, 2'b00, 0, 0, 0, 0);
        n_cmp++; if (obs_vec() !== exp_vec) begin n_fail++; $display("FAIL rd_access: got %h want %h", obs_vec(), exp_vec); end
        advance();
        apply(2'b00, 2'b00, 0, 0, 0, 0);
        n_cmp++;
        if (bus.rsp_valid !== 2'b10 || bus.rsp_data !== 32'hAAAAAAAA) begin
            n_fail++; $display("FAIL rd_data: got rsp_valid=%b data=%h want 10/aaaaaaaa", bus.rsp_valid, bus.rsp_data);
        end
        advance();
    endtask

    task automatic test_contention();
        logic [1:0] grants [0:3];
        for (int c = 0; c < 12; c++) begin
            apply(2'b11, 2'b00, 2, 5, 0, 0);
            n_cmp++; if (obs_vec() !== exp_vec) begin n_fail++; $display("FAIL cont_cycle%0d: got %h want %h", c, obs_vec(), exp_vec); end
            if (c % 3 == 0) begin
                grants[c / 3] = bus.gnt;
                n_cmp++;
                if (bus.gnt !== (((c / 3) % 2 == 0) ? 2'b01 : 2'b10)) begin
                    n_fail++; $display("FAIL cont_order%0d: got %b want %b", c / 3, bus.gnt, ((c / 3) % 2 == 0) ? 2'b01 : 2'b10);
                end
            end
            if (c % 3 == 2) begin
                n_cmp++;
                if (bus.rsp_valid !== grants[c / 3]) begin
                    n_fail++; $display("FAIL cont_rsp%0d: got %b want %b", c / 3, bus.rsp_valid, grants[c / 3]);
                end
            end
            advance();
        end
    endtask

    task automatic test_fill();
        logic [DW-1:0] want;
        for (int a = 0; a < 8; a++) begin
            want = 32'h11111111 * (a + 1);
            apply(2'b01, 2'b01, a[AW-1:0], 0, want, 0);
            n_cmp++; if (obs_vec() !== exp_vec) begin n_fail++; $display("FAIL fill_wr_grant%0d: got %h want %h", a, obs_vec(), exp_vec); end
            advance();
            for (int i = 0; i < 2; i++) begin
                apply(2'b00, 2'b00, 0, 0, 0, 0);
                n_cmp++; if (obs_vec() !== exp_vec) begin n_fail++; $display("FAIL fill_wr%0d_c%0d: got %h want %h", a, i, obs_vec(), exp_vec); end
                advance();
            end
        end
        for (int a = 0; a < 8; a++) begin
            want = 32'h11111111 * (a + 1);
            apply(2'b01, 2'b00, a[AW-1:0], 0, 0, 0);
            n_cmp++; if (obs_vec() !== exp_vec) begin n_fail++; $display("FAIL fill_rd_grant%0d: got %h want %h", a, obs_vec(), exp_vec); end
            advance();
            apply(2'b00, 2'b00, 0, 0, 0, 0);
            n_cmp++; if (obs_vec() !== exp_vec) begin n_fail++; $display("FAIL fill_rd_access%0d: got %h want %h", a, obs_vec(), exp_vec); end
            advance();
            apply(2'b00, 2'b00, 0, 0, 0, 0);
            n_cmp++; if (bus.rsp_data !== want) begin n_fail++; $display("FAIL fill_readback%0d: got %h want %h", a, bus.rsp_data, want); end
            advance();
        end
    endtask

    task automatic test_withdraw();
        apply(2'b01, 2'b00, 3, 0, 0, 0);
        n_cmp++; if (obs_vec() !== exp_vec) begin n_fail++; $display("FAIL wd_grant: got %h want %h", obs_vec(), exp_vec); end
        advance();
        for (int i = 0; i < 2; i++) begin
            apply(2'b10, 2'b10, 0, 6, 0, 32'hDEADBEEF);
            n_cmp++; if (bus.gnt !== 2'b00) begin n_fail++; $display("FAIL wd_busy_gnt%0d: got %b want 00", i, bus.gnt); end
            n_cmp++; if (obs_vec() !== exp_vec) begin n_fail++; $display("FAIL wd_busy%0d: got %h want %h", i, obs_vec(), exp_vec); end
            advance();
        end
        for (int i = 0; i < 3; i++) begin
            apply(2'b00, 2'b00, 0, 0, 0, 0);
            n_cmp++;
            if (bus.gnt !== 2'b00 || bus.mem_dmem !== 1'b0 || bus.mem_addr !== 3'd3) begin
                n_fail++; $display("FAIL wd_idle%0d: got gnt=%b dmem=%b addr=%0d want 00/0/3", i, bus.gnt, bus.mem_dmem, bus.mem_addr);
            end
            advance();
        end
    endtask

    task automatic test_resp_request();
        apply(2'b01, 2'b00, 4, 0, 0, 0);
        n_cmp++; if (obs_vec() !== exp_vec) begin n_fail++; $display("FAIL rr_grant: got %h want %h", obs_vec(), exp_vec); end
        advance();
        apply(2'b00, 2'b00, 0, 0, 0, 0);
        advance();
        apply(2'b01, 2'b00, 7, 0, 0, 0);
        n_cmp++;
        if (bus.gnt !== 2'b00 || bus.rsp_valid !== 2'b01) begin
            n_fail++; $display("FAIL rr_in_resp: got gnt=%b rsp_valid=%b want 00/01", bus.gnt, bus.rsp_valid);
        end
        advance();
        apply(2'b01, 2'b00, 7, 0, 0, 0);
        n_cmp++; if (bus.gnt !== 2'b01) begin n_fail++; $display("FAIL rr_next_idle: got %b want 01", bus.gnt); end
        advance();
        for (int i = 0; i < 2; i++) begin
            apply(2'b00, 2'b00, 0, 0, 0, 0);
            n_cmp++; if (obs_vec() !== exp_vec) begin n_fail++; $display("FAIL rr_tail%0d: got %h want %h", i, obs_vec(), exp_vec); end
            advance();
        end
    endtask

    task automatic test_random();
        logic          pend [2];
        logic          pwe  [2];
        logic [AW-1:0] pad  [2];
        logic [DW-1:0] pwd  [2];
        logic [1:0]    rq;
        logic [1:0]    wv;
        pend[0] = 1'b0; pend[1] = 1'b0;
        for (int p = 0; p < 2; p++) begin pwe[p] = 1'b0; pad[p] = '0; pwd[p] = '0; end
        for (int c = 0; c < 400; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && $urandom_range(0, 2) == 0) begin
                    pend[p] = 1'b1;
                    pwe[p]  = 1'($urandom_range(0, 1));
                    pad[p]  = AW'($urandom_range(0, 7));
                    pwd[p]  = $urandom;
                end else if (pend[p] && $urandom_range(0, 15) == 0) begin
                    pend[p] = 1'b0;
                end
            end
            rq = {pend[1], pend[0]};
            wv = {pwe[1], pwe[0]};
            apply(rq, wv, pad[0], pad[1], pwd[0], pwd[1]);
            n_cmp++; if (obs_vec() !== exp_vec) begin n_fail++; $display("FAIL rand_cycle%0d: got %h want %h", c, obs_vec(), exp_vec); end
            if (exp_gnt[0]) pend[0] = 1'b0;
            if (exp_gnt[1]) pend[1] = 1'b0;
            advance();
        end
    endtask

    initial begin
        bus.req = '0; bus.we = '0;
        bus.addr0 = '0; bus.addr1 = '0;
        bus.wdata0 = '0; bus.wdata1 = '0;
        model_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_write_read();
        test_contention();
        test_fill();
        test_withdraw();
        test_resp_request();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and sequencer for the single-port data memory `mem` in the RISC-V core. It shares the memory between the instruction-fetch port (port 0) and the load/store port (port 1). Each access is sequenced through a fixed three-cycle request/access/response flow. Arbitration is round-robin, so neither port starves, and write-enable is only ever driven inside a clean access cycle.

## Interface
- `ADDR_W`, default 3: memory address width; matches the `mem` instance depth of 2^ADDR_W words.
- `DATA_W`, default 32: data word width.

- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `req`  in  2  per-port access request; bit i belongs to port i.
- `we`  in  2  per-port write flag (1 = write, 0 = read); qualified by `req[i]`.
- `addr0`, `addr1`  in  ADDR_W each  per-port word address.
- `wdata0`, `wdata1`  in  DATA_W each  per-port write data.
- `gnt`  out  2  one-hot grant pulse; `req[i] & gnt[i]` means the request is accepted.
- `rsp_valid`  out  2  one-hot completion pulse to the granted port.
- `rsp_data`  out  DATA_W  read data; valid only while `rsp_valid` is nonzero.
- `mem_dmem`  out  1  memory write enable (1 = write); connects to `mem.dmem`.
- `mem_addr`  out  ADDR_W  memory address; connects to `mem.addr`.
- `mem_data_w`  out  DATA_W  memory write data; connects to `mem.data_w`.
- `mem_data_r`  in  DATA_W  memory read data; `mem` has a synchronous read with one-cycle latency.

## Operation
- FSM states: IDLE → ACCESS → RESP → IDLE. There is no other path, and reset returns the FSM to IDLE.
- **IDLE**
  - If any `req` bit is high, the winner's `gnt` bit is asserted combinationally in that cycle.
  - The winner's addr, wdata, we and port index are latched at the clock edge, and the FSM moves to ACCESS.
  - If no request is present, the FSM stays in IDLE.
- **Arbitration**
  - A single request wins outright.
  - If both ports request, the port not granted last wins.
  - `last_gnt` updates only on a grant.
  - `last_gnt` resets to 1, so port 0 wins the first contention.
- **ACCESS**
  - `mem_addr` and `mem_data_w` are driven from the latched values, and `mem_dmem` equals the latched we.
  - The FSM always moves to RESP.
- **RESP**
  - `rsp_valid[port]` = 1 for exactly one cycle.
  - `rsp_data` = `mem_data_r` for reads. For writes, `rsp_data` = 0 and `rsp_valid` still pulses as the write acknowledge.
  - `gnt` = 0, and the FSM moves to IDLE.
- Requests are ignored outside IDLE, and `gnt` is 0 outside IDLE.
  - A requester holds `req`, `we`, addr and wdata stable until it sees its `gnt`.
  - Dropping `req` before `gnt` is legal and has no effect.
- `mem_dmem` = 0 in every state except ACCESS with latched we = 1. This rule is absolute.
- `mem_addr` holds its last latched value outside ACCESS; reads there are harmless.

## Timing
- Request sampled and granted in cycle N; memory access in N+1; `rsp_valid` in N+2; next grant possible in N+3.
- Throughput: one access per 3 cycles. Back-to-back contention alternates 0,1,0,1.
- Write commits at the rising edge that ends cycle N+1.
- Reset values (asserted asynchronously):
  - FSM = IDLE, `last_gnt` = 1.
  - `gnt` = 0, `rsp_valid` = 0, `rsp_data` = 0.
  - `mem_dmem` = 0, `mem_addr` = 0, `mem_data_w` = 0.
- Reset mid-operation aborts the access:
  - No `rsp_valid` is issued.
  - A write in ACCESS may or may not commit.
  - `mem_dmem` falls immediately on reset assertion.
- Simultaneous request and response:
  - A request arriving while the FSM is in RESP is not granted until the following IDLE cycle.
  - The same port may re-request immediately after its `rsp_valid`.

## Structure
- `mem_arb_pkg` holds:
  - `state_t` enum {IDLE, ACCESS, RESP}
  - constants `PORT_IF` = 0, `PORT_LS` = 1
- Sub-module `rr_arbiter2`:
  - Contains the 2-input round-robin pick and the `last_gnt` register.
  - Inputs: `clk`, `rst`, `req`, `update`. Output: `gnt`.
- The top level contains the FSM, the access latch, and the memory-side muxing.

## Test plan
- **Reset:** assert `rst` = 0 mid-RESP. Expect `rsp_valid` = 0 and `mem_dmem` = 0 immediately; after release the FSM is in IDLE and port 0 wins the first contention.
- **Single write then read:**
  - Port 1 writes 32'hAAAAAAAA to address 2: `gnt` = 2'b10 in N, `mem_dmem` = 1 only in N+1, `rsp_valid` = 2'b10 in N+2.
  - Port 1 then reads address 2: `rsp_data` = 32'hAAAAAAAA.
- **Contention:** hold `req` = 2'b11 for 12 cycles. Expect grants 01, 10, 01, 10 every 3 cycles, and each `rsp_valid` matches the prior grant.
- **Fill and readback:** port 0 writes addresses 0–7 with 32'h11111111 × (addr+1), then reads all 8. Every readback matches, and no write appears in RESP or IDLE cycles.
- **Request withdrawal:** port 1 raises `req` during ACCESS of a port-0 access and drops it before IDLE. Expect no grant to port 1 and no memory activity for it.
- **Response-cycle request:** port 0 re-requests in its own RESP cycle. Expect it to be granted exactly one cycle later, in IDLE.
